inst_rom_resp: RTL

- Instruction-memory responder serving fetch requests from the PC/fetch stage.
- Holds a word-organised instruction store, written through a loader (backdoor program-load) port.
- Returns instructions through a request/valid handshake with a configurable number of wait states, so the fetch stage can be exercised against slow memory.
- Sits between the fetch stage and the program image; replaces a zero-latency combinational ROM in the top-level and benches.

---
 rtl/inst_rom_resp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_rom_resp.sv
// Instruction store with loader backdoor, answering fetches after WAIT_STATES extra cycles.
// Latency: valid in the cycle after edge k+1+WAIT_STATES; requests are ignored while busy_o is high.
module inst_rom_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  req_i,
    input  logic [31:0]           addr_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    output logic                  busy_o,
    output logic                  err_o,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  mis_q, mis_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    // Loader is independent of the fetch FSM; nonblocking update gives read-before-write on collision.
    always_ff @(posedge clk) begin
        if (!rst && ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;

        if (!ce_i) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            inst_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        idx_d   = addr_i[ADDR_WIDTH+1:2];
                        mis_d   = (addr_i[1:0] != 2'b00);
                        busy_d  = 1'b1;
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_RESP;
                    end
                end
                S_RESP: begin
                    inst_d  = mis_q ? '0 : mem[idx_q];
                    valid_d = 1'b1;
                    err_d   = mis_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule
